// File: rtl/ahb_cmd_master_if.sv
// rtl/ahb_cmd_master_if.sv - command stream, AHB-lite bus and response signals of ahb_cmd_master
interface ahb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hrdata,
        output cmd_ready, htrans, hwrite, haddr, hwdata,
               rsp_valid, rsp_write, rsp_rdata, busy, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hrdata,
        input  cmd_ready, htrans, hwrite, haddr, hwdata,
               rsp_valid, rsp_write, rsp_rdata, busy, timeout_err
    );
endinterface

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - pipelined AHB-lite single-transfer master driven by a command stream
module ahb_cmd_master #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic hclk,
    input  logic hreset,
    ahb_cmd_master_if.master bus
);
    localparam logic [8:0] MAX_WAIT_L = 9'(MAX_WAIT);
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

    logic              a_valid;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              d_valid;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [7:0]        wait_cnt;
    logic [8:0]        wait_nxt;
    logic              timeout_err;
    logic              accept;

    assign accept   = bus.cmd_valid && bus.hready;
    assign wait_nxt = {1'b0, wait_cnt} + 9'd1;

    assign bus.cmd_ready   = bus.hready && !hreset;
    assign bus.htrans      = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.hwrite      = a_valid && a_write;
    assign bus.haddr       = a_valid ? a_addr : '0;
    assign bus.hwdata      = (d_valid && d_write) ? d_wdata : '0;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_write   = rsp_write;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.busy        = a_valid || d_valid;
    assign bus.timeout_err = timeout_err;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            a_valid     <= 1'b0;
            a_write     <= 1'b0;
            a_addr      <= '0;
            a_wdata     <= '0;
            d_valid     <= 1'b0;
            d_write     <= 1'b0;
            d_wdata     <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (bus.hready) begin
                // Data phase of the current transfer ends while the next address phase begins.
                d_valid <= a_valid;
                d_write <= a_write;
                d_wdata <= a_wdata;
                if (accept) begin
                    a_valid <= 1'b1;
                    a_write <= bus.cmd_write;
                    a_addr  <= bus.cmd_addr;
                    a_wdata <= bus.cmd_wdata;
                end else begin
                    a_valid <= 1'b0;
                end
                rsp_valid <= d_valid;
                if (d_valid) begin
                    rsp_write <= d_write;
                    rsp_rdata <= d_write ? '0 : bus.hrdata;
                end
            end else begin
                rsp_valid <= 1'b0;
            end

            // Wait states are only timed while a data phase is outstanding; the transfer is never aborted.
            if (d_valid && !bus.hready) begin
                if (wait_cnt != 8'hff) begin
                    wait_cnt <= wait_nxt[7:0];
                end
                if (wait_nxt >= MAX_WAIT_L) begin
                    timeout_err <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule
